// File: rtl/b_order_tracker.sv
// Tracks outstanding AXI writes in AW-acceptance order so the B-channel arbiter
// knows which slave owes the next write response.
module b_order_tracker #(
  parameter int DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     AWVALID_M1,
  input  logic                     AWREADY_M1,
  input  logic [31:0]              AWADDR_M1,
  input  logic                     BVALID_M1,
  input  logic                     BREADY_M1,
  output logic [3:0]               round,
  output logic                     aw_stall,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     ovf_err,
  output logic                     unf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    code;
  logic          push, pop, full, is_empty, do_push, do_pop;

  assign push     = AWVALID_M1 & AWREADY_M1;
  assign pop      = BVALID_M1 & BREADY_M1;
  assign full     = (outstanding == FULL_CNT);
  assign is_empty = (outstanding == '0);

  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop & ~is_empty;
  assign do_push = push & (~full | pop);

  always_comb begin
    code = 4'b1000;
    if (AWADDR_M1 <= 32'h0000_FFFF)
      code = 4'b0001;
    else if (AWADDR_M1 <= 32'h0001_FFFF)
      code = 4'b0010;
    else if (AWADDR_M1 >= 32'h2000_0000 && AWADDR_M1 <= 32'h201F_FFFF)
      code = 4'b0100;
  end

  always_ff @(posedge ACLK) begin
    if (do_push)
      mem[wr_ptr] <= code;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (push & full & ~pop)
        ovf_err <= 1'b1;
      if (pop & is_empty)
        unf_err <= 1'b1;
    end
  end

  // Storage is unreset; gating on the count keeps stale entries off round.
  assign round    = is_empty ? 4'b0000 : mem[rd_ptr];
  assign empty    = is_empty;
  assign aw_stall = full & ~pop;

endmodule

// File: tb/tb_b_order_tracker.sv
// Randomised and directed bench for b_order_tracker against a queue-based model.
module tb_b_order_tracker;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        AWVALID_M1, AWREADY_M1, BVALID_M1, BREADY_M1;
  logic [31:0] AWADDR_M1;
  logic [3:0]  round;
  logic        aw_stall, empty, ovf_err, unf_err;
  logic [2:0]  outstanding;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [3:0] q[$];
  logic       m_ovf, m_unf;
  logic       stall_seen, stall_exp;

  b_order_tracker #(.DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1), .AWADDR_M1(AWADDR_M1),
    .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
    .round(round), .aw_stall(aw_stall), .empty(empty),
    .outstanding(outstanding), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [3:0] ref_slave(input logic [31:0] a);
    if (a < 32'h0001_0000) return 4'b0001;
    if (a < 32'h0002_0000) return 4'b0010;
    if (a >= 32'h2000_0000 && a < 32'h2020_0000) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [3:0] m_round();
    return (q.size() == 0) ? 4'b0000 : q[0];
  endfunction

  function automatic logic [9:0] m_state();
    return {m_round(), 3'(q.size()), (q.size() == 0), m_ovf, m_unf};
  endfunction

  // Drive one cycle; sample aw_stall before the edge, then advance the model.
  task automatic cycle(input logic aw, input logic awr, input logic [31:0] addr,
                       input logic b, input logic br);
    int unsigned pre;
    logic        p, r;
    AWVALID_M1 = aw; AWREADY_M1 = awr; AWADDR_M1 = addr;
    BVALID_M1 = b; BREADY_M1 = br;
    #2;
    pre = q.size();
    p = aw & awr;
    r = b & br;
    stall_seen = aw_stall;
    stall_exp  = (pre == 4) && !r;
    @(posedge ACLK);
    if (r && pre == 0) m_unf = 1'b1;
    if (p && pre == 4 && !r) m_ovf = 1'b1;
    if (r && pre > 0) void'(q.pop_front());
    if (p && (pre < 4 || r)) q.push_back(ref_slave(addr));
    #1;
    AWVALID_M1 = 1'b0; AWREADY_M1 = 1'b0; BVALID_M1 = 1'b0; BREADY_M1 = 1'b0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    AWVALID_M1 = 1'b0; AWREADY_M1 = 1'b0; BVALID_M1 = 1'b0; BREADY_M1 = 1'b0;
    AWADDR_M1 = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({round, outstanding, empty, aw_stall, ovf_err, unf_err} !== {4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset: got r=%b o=%0d e=%b s=%b ovf=%b unf=%b", round, outstanding, empty, aw_stall, ovf_err, unf_err);
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    cycle(1, 1, 32'h0001_0004, 0, 0);
    total++;
    if ({round, outstanding} !== {4'b0010, 3'd1})
      $display("FAIL single_push: got r=%b o=%0d, expected r=0010 o=1", round, outstanding);
    else passed++;
    cycle(0, 0, 0, 1, 1);
    total++;
    if ({round, empty} !== {4'b0000, 1'b1})
      $display("FAIL single_pop: got r=%b e=%b, expected r=0000 e=1", round, empty);
    else passed++;
  endtask

  task automatic test_ordering();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000;
    do_reset();
    cycle(1, 1, 32'h0000_0010, 0, 0);
    cycle(1, 1, 32'h2000_0000, 0, 0);
    cycle(1, 1, 32'h4000_0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (round !== exp_seq[i])
        $display("FAIL ordering[%0d]: got %b expected %b", i, round, exp_seq[i]);
      else passed++;
      cycle(0, 0, 0, 1, 1);
    end
    total++;
    if (empty !== 1'b1) $display("FAIL ordering_empty: got %b expected 1", empty);
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    cycle(1, 1, 32'h0000_0100, 0, 0);
    cycle(1, 1, 32'h0001_8000, 0, 0);
    cycle(1, 1, 32'h201F_FFFF, 0, 0);
    cycle(1, 1, 32'h0002_0000, 0, 0);
    total++;
    if (aw_stall !== 1'b1) $display("FAIL full_stall: got %b expected 1", aw_stall);
    else passed++;
    cycle(1, 1, 32'h0000_0000, 0, 0);
    total++;
    if ({ovf_err, outstanding, round} !== {1'b1, 3'd4, 4'b0001})
      $display("FAIL full_ovf: got ovf=%b o=%0d r=%b expected ovf=1 o=4 r=0001", ovf_err, outstanding, round);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    cycle(1, 1, 32'h0000_0000, 0, 0);
    cycle(1, 1, 32'h0001_0000, 0, 0);
    cycle(1, 1, 32'h2000_0004, 0, 0);
    cycle(1, 1, 32'h8000_0000, 0, 0);
    cycle(1, 1, 32'h0000_FFFF, 1, 1);
    total++;
    if (stall_seen !== 1'b0) $display("FAIL fullpp_stall: got %b expected 0", stall_seen);
    else passed++;
    total++;
    if ({outstanding, ovf_err, round} !== {3'd4, 1'b0, 4'b0010})
      $display("FAIL fullpp_state: got o=%0d ovf=%b r=%b expected o=4 ovf=0 r=0010", outstanding, ovf_err, round);
    else passed++;
    repeat (3) cycle(0, 0, 0, 1, 1);
    total++;
    if (round !== 4'b0001) $display("FAIL fullpp_tail: got %b expected 0001", round);
    else passed++;
  endtask

  task automatic test_underflow_wrap();
    logic [31:0] a;
    do_reset();
    cycle(0, 0, 0, 1, 1);
    total++;
    if ({unf_err, outstanding} !== {1'b1, 3'd0})
      $display("FAIL underflow: got unf=%b o=%0d expected unf=1 o=0", unf_err, outstanding);
    else passed++;
    cycle(1, 1, 32'h0001_0000, 1, 1);
    total++;
    if ({outstanding, round} !== {3'd1, 4'b0010})
      $display("FAIL empty_pushpop: got o=%0d r=%b expected o=1 r=0010", outstanding, round);
    else passed++;
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      a = (i % 3 == 0) ? 32'h2010_0000 : (i % 3 == 1) ? 32'h0000_1234 : 32'hFFFF_FFFF;
      cycle(1, 1, a, 0, 0);
      total++;
      if (round !== ref_slave(a))
        $display("FAIL wrap[%0d]: got %b expected %b", i, round, ref_slave(a));
      else passed++;
      cycle(0, 0, 0, 1, 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] edges [5];
    edges[0] = 32'h0000_FFFF; edges[1] = 32'h0002_0000; edges[2] = 32'h1FFF_FFFF;
    edges[3] = 32'h2020_0000; edges[4] = 32'h201F_FFFF;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 32'hFFFF);
        1: a = 32'h0001_0000 | $urandom_range(0, 32'hFFFF);
        2: a = 32'h2000_0000 | ($urandom & 32'h001F_FFFF);
        3: a = $urandom;
        default: a = edges[$urandom_range(0, 4)];
      endcase
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8, a,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 8);
      total++;
      if (stall_seen !== stall_exp)
        $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall_seen, stall_exp);
      else passed++;
      total++;
      if ({round, outstanding, empty, ovf_err, unf_err} !== m_state())
        $display("FAIL rand_state[%0d]: got %b expected %b", i,
                 {round, outstanding, empty, ovf_err, unf_err}, m_state());
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 1, 32'h0000_0004, 0, 0);
    cycle(1, 1, 32'h0001_0004, 0, 0);
    cycle(1, 1, 32'h2000_0004, 0, 0);
    #3 ARESETn = 1'b0;
    #1;
    total++;
    if ({round, empty, outstanding, aw_stall} !== {4'b0000, 1'b1, 3'd0, 1'b0})
      $display("FAIL async_reset: got r=%b e=%b o=%0d s=%b", round, empty, outstanding, aw_stall);
    else passed++;
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    cycle(1, 1, 32'h7000_0000, 0, 0);
    total++;
    if ({round, outstanding} !== {4'b1000, 3'd1})
      $display("FAIL post_reset: got r=%b o=%0d expected r=1000 o=1", round, outstanding);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_full();
    test_full_push_pop();
    test_underflow_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
